spram_arbiter: RTL and testbench
================================

Name: spram_arbiter

Overview:
Shares one 1-cycle-latency single-port SRAM (sync_spram) between NUM_REQ requesters. Arbitration is round-robin with a valid/ready request handshake and a fixed-latency response. After reset, and on request, an init sequencer sweeps the array to zero before any access is accepted. Used in front of tag/valid arrays in caches and TLBs, where clean initial contents and multi-source access are both required.

Parameters:
NUM_REQ, 2, number of requesters (>=1)
DATA_WIDTH, 32, SRAM word width
DATA_DEPTH, 1024, SRAM word count; AW = $clog2(DATA_DEPTH)
BYTE_SIZE, 32, write-enable granularity; WEW = DATA_WIDTH/BYTE_SIZE
INIT_EN, 1, 1 = zero-fill the array after reset and on clear_i; 0 = skip init

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
clear_i  in  1  single-cycle pulse requesting a re-zero of the array (ignored if INIT_EN=0)
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester grant; a transfer occurs when valid & ready
req_addr_i  in  NUM_REQ*AW  request addresses, packed; requester i at [i*AW +: AW]
req_we_i  in  NUM_REQ*WEW  byte write enables, packed; all-zero = read
req_wdata_i  in  NUM_REQ*DATA_WIDTH  write data, packed
resp_valid_o  out  NUM_REQ  one-hot pulse, one cycle after the accepted request
resp_rdata_o  out  DATA_WIDTH  read data for the responding requester
init_done_o  out  1  high while the block is in RUN
sram_addr_o  out  AW  to sync_spram addr_i
sram_en_o  out  1  to sync_spram en_i
sram_we_o  out  WEW  to sync_spram we_i
sram_wdata_o  out  DATA_WIDTH  to sync_spram wdata_i
sram_rdata_i  in  DATA_WIDTH  from sync_spram rdata_o

Behaviour:
- FSM states: INIT, RUN.
  - rst: state<=INIT (INIT_EN=1) or RUN (INIT_EN=0); init_cnt<=0; rr_ptr<=0; resp_valid_o<=0.
- INIT:
  - Each cycle drive sram_en_o=1, sram_we_o all ones, sram_wdata_o=0, sram_addr_o=init_cnt; then init_cnt++.
  - When init_cnt==DATA_DEPTH-1 is written, move to RUN next cycle. The sweep takes exactly DATA_DEPTH cycles.
  - req_ready_o=0 and init_done_o=0 throughout.
  - clear_i in INIT resets init_cnt to 0 (restart the sweep).
- RUN:
  - init_done_o=1.
  - Grant is combinational from req_valid_i and rr_ptr: pick the first valid index scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ. At most one bit of req_ready_o is high, and only for a valid requester.
  - On grant to requester g: sram_en_o=1; sram_addr_o, sram_we_o and sram_wdata_o come from requester g in the same cycle; rr_ptr<=(g+1) mod NUM_REQ.
  - No valid requests: sram_en_o=0, rr_ptr unchanged, SRAM outputs don't-care except en.
- Response:
  - Request accepted in cycle t gives resp_valid_o[g]=1 in cycle t+1 only, for both reads and writes.
  - resp_rdata_o = sram_rdata_i (combinational pass-through) and is valid only for reads. For writes its value is don't-care.
  - No response backpressure. Throughput is one access per cycle total.
- clear_i in RUN:
  - No grant in that cycle.
  - State<=INIT and init_cnt<=0 next cycle.
  - A request accepted in the cycle before clear_i still produces its response in the cycle clear_i is high.
- Reset mid-operation: pending response is dropped (resp_valid_o=0 next cycle) and init restarts at address 0.
- A requester must hold addr, we and wdata stable while valid is high and not granted. The arbiter does not latch them.
- NUM_REQ=1: rr_ptr stays 0, and the grant equals req_valid_i[0] in RUN.

Test Plan:
- Reset, DATA_DEPTH=16, INIT_EN=1 -> sram_en_o=1, we all ones, wdata=0, addr 0..15 on cycles 1..16; init_done_o rises on cycle 17; req_ready_o=0 before that.
- RUN: req0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> resp_valid_o=2'b01 one cycle after each grant; read returns resp_rdata_o=0xDEADBEEF.
- req0 and req1 valid continuously with reads of addr 1 and 2 -> grants alternate 0,1,0,1 starting at 0; resp_valid_o pattern 01,10,01,10 lagging by one cycle; data alternates between addr1 and addr2 contents.
- Only req1 valid for 4 cycles -> granted every cycle; rr_ptr wraps to 0; then both valid -> req0 granted first.
- Read addr 5 accepted, clear_i on the next cycle -> response with 0xDEADBEEF delivered during the clear cycle; 16-cycle re-sweep follows; read addr 5 afterwards returns 0.
- rst asserted at init_cnt=7 -> next cycle sram_addr_o=0 and sweep restarts; rst asserted one cycle after a grant -> no resp_valid_o pulse.

Source files
------------

// File: rtl/spram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: packed per-requester
// request channel plus one-hot fixed-latency response.
interface spram_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 10,
    parameter int WEW        = 1
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ*AW-1:0]         req_addr_i;
    logic [NUM_REQ*WEW-1:0]        req_we_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]            resp_valid_o;
    logic [DATA_WIDTH-1:0]         resp_rdata_o;

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o
    );
endinterface

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one 1-cycle single-port SRAM between
// NUM_REQ requesters, with a zero-fill sweep after reset or clear.
module spram_arbiter #(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int DATA_DEPTH = 1024,
    parameter  int BYTE_SIZE  = 32,
    parameter  int INIT_EN    = 1,
    localparam int AW         = $clog2(DATA_DEPTH),
    localparam int WEW        = DATA_WIDTH / BYTE_SIZE,
    localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    spram_arbiter_if.slave        bus,
    output logic                  init_done_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic                  sram_en_o,
    output logic [WEW-1:0]        sram_we_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(DATA_DEPTH - 1);

    state_t             r_state;
    logic [AW-1:0]      r_init_cnt;
    logic [PW-1:0]      r_rr_ptr;
    logic [NUM_REQ-1:0] r_resp_valid;

    logic               w_clear;
    logic               w_any;
    logic               w_fire;
    logic [PW-1:0]      w_scan;
    logic [PW-1:0]      w_gidx;
    logic [PW-1:0]      w_next_ptr;
    logic [NUM_REQ-1:0] w_grant;

    function automatic logic [PW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    assign w_clear = clear_i && (INIT_EN != 0);

    // First valid requester scanning upward from the round-robin pointer
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_scan = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = wrap_idx(int'(r_rr_ptr), k);
            if (!w_any && bus.req_valid_i[w_scan]) begin
                w_any  = 1'b1;
                w_gidx = w_scan;
            end
        end
    end

    assign w_fire     = (r_state == S_RUN) && !w_clear && w_any;
    assign w_grant    = w_fire ? (NUM_REQ'(1) << w_gidx) : '0;
    assign w_next_ptr = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + PW'(1);

    always_comb begin
        sram_en_o    = 1'b0;
        sram_addr_o  = '0;
        sram_we_o    = '0;
        sram_wdata_o = '0;
        if (r_state == S_INIT) begin
            sram_en_o   = 1'b1;
            sram_addr_o = r_init_cnt;
            sram_we_o   = '1;
        end else if (w_fire) begin
            sram_en_o    = 1'b1;
            sram_addr_o  = bus.req_addr_i[w_gidx*AW +: AW];
            sram_we_o    = bus.req_we_i[w_gidx*WEW +: WEW];
            sram_wdata_o = bus.req_wdata_i[w_gidx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= (INIT_EN != 0) ? S_INIT : S_RUN;
            r_init_cnt   <= '0;
            r_rr_ptr     <= '0;
            r_resp_valid <= '0;
        end else begin
            r_resp_valid <= w_grant;
            if (w_fire) r_rr_ptr <= w_next_ptr;
            unique case (r_state)
                S_INIT: begin
                    if (w_clear) begin
                        r_init_cnt <= '0;
                    end else if (r_init_cnt == LAST) begin
                        r_state    <= S_RUN;
                        r_init_cnt <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + AW'(1);
                    end
                end
                S_RUN: begin
                    if (w_clear) begin
                        r_state    <= S_INIT;
                        r_init_cnt <= '0;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.req_ready_o  = w_grant;
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_rdata_o = sram_rdata_i;
    assign init_done_o      = (r_state == S_RUN);
endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a byte-enable SRAM model,
// 2 requesters, 16-word array, 8-bit write lanes.
module tb_spram_arbiter;
    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int DD  = 16;
    localparam int BS  = 8;
    localparam int AW  = 4;
    localparam int WEW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_i;
    logic          init_done;
    logic          sram_en;
    logic [AW-1:0] sram_addr;
    logic [WEW-1:0] sram_we;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [DW-1:0] mem [DD];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .AW(AW), .WEW(WEW)) bus ();

    spram_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .DATA_DEPTH(DD),
        .BYTE_SIZE(BS), .INIT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .bus(bus),
        .init_done_o(init_done), .sram_addr_o(sram_addr),
        .sram_en_o(sram_en), .sram_we_o(sram_we),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= mem[sram_addr];
            for (int b = 0; b < WEW; b++)
                if (sram_we[b]) mem[sram_addr][b*BS +: BS] <= sram_wdata[b*BS +: BS];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic v, input logic [AW-1:0] a,
                           input logic [WEW-1:0] we, input logic [DW-1:0] d);
        bus.req_valid_i[r]          = v;
        bus.req_addr_i[r*AW +: AW]  = a;
        bus.req_we_i[r*WEW +: WEW]  = we;
        bus.req_wdata_i[r*DW +: DW] = d;
    endtask

    initial begin
        rst = 1'b1;
        clear_i = 1'b0;
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_we_i    = '0;
        bus.req_wdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        smp();
        chk("rst_done", init_done, 0);
        chk("rst_resp", bus.resp_valid_o, 0);
        chk("rst_rdy", bus.req_ready_o, 0);

        nxt();
        rst = 1'b0;
        bus.req_valid_i = 2'b11;
        for (int i = 0; i < DD; i++) begin
            smp();
            chk("init_en", sram_en, 1);
            chk("init_we", sram_we, 4'hf);
            chk("init_wdata", sram_wdata, 0);
            chk("init_addr", sram_addr, i);
            chk("init_rdy", bus.req_ready_o, 0);
            chk("init_done_lo", init_done, 0);
            nxt();
        end
        bus.req_valid_i = '0;
        smp();
        chk("done_hi", init_done, 1);
        chk("idle_en", sram_en, 0);

        nxt();
        set_req(0, 1, 5, 4'hf, 32'hDEADBEEF);
        smp();
        chk("wr_rdy", bus.req_ready_o, 2'b01);
        chk("wr_addr", sram_addr, 5);
        chk("wr_we", sram_we, 4'hf);
        chk("wr_wdata", sram_wdata, 32'hDEADBEEF);
        nxt();
        set_req(0, 1, 5, 4'h0, 0);
        smp();
        chk("wr_resp", bus.resp_valid_o, 2'b01);
        chk("rd_rdy", bus.req_ready_o, 2'b01);
        nxt();
        set_req(0, 0, 0, 0, 0);
        smp();
        chk("rd_resp", bus.resp_valid_o, 2'b01);
        chk("rd_data", bus.resp_rdata_o, 32'hDEADBEEF);

        // Only requester 1 for four cycles; pointer wraps back to 0
        nxt();
        set_req(1, 1, 1, 4'hf, 32'h11111111);
        smp();
        chk("r1a_rdy", bus.req_ready_o, 2'b10);
        chk("r1a_resp", bus.resp_valid_o, 2'b00);
        nxt();
        set_req(1, 1, 2, 4'b0011, 32'hAAAA2222);
        smp();
        chk("r1b_rdy", bus.req_ready_o, 2'b10);
        chk("r1b_resp", bus.resp_valid_o, 2'b10);
        nxt();
        set_req(1, 1, 1, 4'h0, 0);
        smp();
        chk("r1c_rdy", bus.req_ready_o, 2'b10);
        chk("r1c_resp", bus.resp_valid_o, 2'b10);
        nxt();
        set_req(1, 1, 2, 4'h0, 0);
        smp();
        chk("r1d_rdy", bus.req_ready_o, 2'b10);
        chk("r1d_resp", bus.resp_valid_o, 2'b10);
        chk("r1d_data", bus.resp_rdata_o, 32'h11111111);

        nxt();
        set_req(0, 1, 1, 4'h0, 0);
        set_req(1, 1, 2, 4'h0, 0);
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("alt_rdy", bus.req_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt_resp", bus.resp_valid_o, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("alt_data", bus.resp_rdata_o, (k % 2 == 0) ? 32'h00002222 : 32'h11111111);
            nxt();
        end
        set_req(1, 0, 0, 0, 0);
        set_req(0, 1, 5, 4'h0, 0);
        smp();
        chk("pre_clr_rdy", bus.req_ready_o, 2'b01);
        chk("pre_clr_resp", bus.resp_valid_o, 2'b10);
        chk("pre_clr_data", bus.resp_rdata_o, 32'h00002222);

        nxt();
        clear_i = 1'b1;
        smp();
        chk("clr_rdy", bus.req_ready_o, 2'b00);
        chk("clr_resp", bus.resp_valid_o, 2'b01);
        chk("clr_data", bus.resp_rdata_o, 32'hDEADBEEF);
        nxt();
        clear_i = 1'b0;
        for (int i = 0; i < DD; i++) begin
            smp();
            chk("swp_addr", sram_addr, i);
            chk("swp_en", sram_en, 1);
            chk("swp_done", init_done, 0);
            chk("swp_rdy", bus.req_ready_o, 0);
            chk("swp_resp", bus.resp_valid_o, 0);
            nxt();
        end
        smp();
        chk("post_rdy", bus.req_ready_o, 2'b01);
        chk("post_done", init_done, 1);
        nxt();
        set_req(0, 0, 0, 0, 0);
        smp();
        chk("post_resp", bus.resp_valid_o, 2'b01);
        chk("post_data", bus.resp_rdata_o, 0);

        // Reset in the middle of a sweep
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("mid_addr", sram_addr, i);
            if (i < 7) nxt();
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        smp();
        chk("rst7_addr", sram_addr, 0);
        nxt();
        smp();
        chk("rst7_addr1", sram_addr, 1);
        nxt();
        for (int i = 2; i < DD; i++) begin
            smp();
            chk("rst7_swp", sram_addr, i);
            nxt();
        end

        // Reset lands on the edge that would register a response
        set_req(0, 1, 5, 4'h0, 0);
        smp();
        chk("g_rdy", bus.req_ready_o, 2'b01);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        set_req(0, 0, 0, 0, 0);
        smp();
        chk("drop_resp", bus.resp_valid_o, 2'b00);
        chk("drop_addr", sram_addr, 0);
        chk("drop_en", sram_en, 1);
        chk("drop_done", init_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
